// File: rtl/acc_pkg.sv
// Shared types and constants for the hash accelerator sequencer: FSM states,
// ACB status codes, control-word bit positions and the digest offset.
package acc_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD_BLK,
    WR_BUSY,
    INIT,
    UPD1,
    HASH,
    UPD2,
    NEXT,
    WR_HASH,
    WR_STAT
  } state_t;

  localparam logic [31:0] STAT_BUSY    = 32'h5;
  localparam logic [31:0] STAT_DONE    = 32'h2;
  localparam logic [31:0] STAT_ABORT   = 32'h12;
  localparam logic [31:0] STAT_TIMEOUT = 32'hA;

  localparam int CTRL_START  = 0;
  localparam int CTRL_DOUBLE = 1;
  localparam int CTRL_ABORT  = 3;

  localparam int DIGEST_OFS = 8;

  localparam logic [2:0] SEL_DIGEST = 3'd7;

endpackage

// File: rtl/acc_cycle_counter.sv
// Free-running cycle counter with synchronous clear; clear wins over enable.
// Count is registered, so a clear is visible on the following cycle.
module acc_cycle_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/acc_seq_control_unit.sv
// Sequencer for the hash accelerator: snoops the CPU control write, fetches blocks,
// drives scheduler/compressor, writes the digest and status back via the arbiter.
module acc_seq_control_unit
  import acc_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 32,
  parameter int                BLOCK_W     = 512,
  parameter logic [ADDR_W-1:0] HCB_START   = 16'h1000,
  parameter logic [ADDR_W-1:0] ACB_START   = 16'h5000,
  parameter int                NUM_BLOCKS  = 2,
  parameter int                HASH_ROUNDS = 64,
  parameter int                TIMEOUT     = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             listen_en,
  input  logic [ADDR_W-1:0]                listen_addr,
  input  logic [DATA_W-1:0]                listen_data,
  input  logic                             rd_valid,
  input  logic                             wr_done,
  input  logic [255:0]                     cm_out,
  output logic                             rd_en,
  output logic [ADDR_W-1:0]                rd_addr,
  output logic                             wr_en,
  output logic [ADDR_W-1:0]                wr_addr,
  output logic [DATA_W-1:0]                wr_data,
  output logic                             ms_init,
  output logic                             ms_enable,
  output logic                             cm_rst_hash_n,
  output logic                             cm_update_A_H,
  output logic                             cm_update_H0_7,
  output logic                             cm_is_hashing,
  output logic [$clog2(HASH_ROUNDS):0]     cm_cycle_count,
  output logic [2:0]                       msg_sel,
  output logic                             hash_done
);

  localparam int BLOCK_B = BLOCK_W / 8;
  localparam int CC_W    = $clog2(HASH_ROUNDS) + 1;
  localparam int WD_W    = $clog2(TIMEOUT + 1);

  state_t              state_q, state_d;
  logic [2:0]          blk_q, blk_d;
  logic [2:0]          word_q, word_d;
  logic                dbl_q, dbl_d;
  logic                dig_pass_q, dig_pass_d;
  logic [DATA_W-1:0]   stat_q, stat_d;
  logic [CC_W-1:0]     round_cnt;
  logic [WD_W-1:0]     wd_cnt;
  logic                ctrl_wr, abort, wd_expired, last_round;
  logic                round_clr, round_en, wd_clr, wd_en;
  logic                unused_ok;

  assign ctrl_wr    = listen_en && (listen_addr == ACB_START);
  assign abort      = ctrl_wr && listen_data[CTRL_ABORT];
  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));
  assign last_round = (round_cnt == CC_W'(HASH_ROUNDS - 1));
  assign unused_ok  = ^{listen_data[DATA_W-1:CTRL_ABORT+1], listen_data[CTRL_ABORT-1]};

  // Round counter only runs while staying in HASH, so it reads 0 on entry.
  assign round_clr = (state_d != HASH);
  assign round_en  = (state_q == HASH);

  // Watchdog restarts on every state change and on each committed digest word.
  assign wd_clr = (state_d != state_q) || ((state_q == WR_HASH) && wr_done);
  assign wd_en  = (state_q == RD_BLK) || (state_q == WR_BUSY) || (state_q == WR_HASH);

  acc_cycle_counter #(.W(CC_W)) u_round_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (round_clr),
    .en    (round_en),
    .count (round_cnt)
  );

  acc_cycle_counter #(.W(WD_W)) u_wd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wd_clr),
    .en    (wd_en),
    .count (wd_cnt)
  );

  assign cm_cycle_count = round_cnt;
  assign msg_sel        = dig_pass_q ? SEL_DIGEST : blk_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      blk_q      <= '0;
      word_q     <= '0;
      dbl_q      <= 1'b0;
      dig_pass_q <= 1'b0;
      stat_q     <= '0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      word_q     <= word_d;
      dbl_q      <= dbl_d;
      dig_pass_q <= dig_pass_d;
      stat_q     <= stat_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    blk_d          = blk_q;
    word_d         = word_q;
    dbl_d          = dbl_q;
    dig_pass_d     = dig_pass_q;
    stat_d         = stat_q;
    rd_en          = 1'b0;
    rd_addr        = '0;
    wr_en          = 1'b0;
    wr_addr        = '0;
    wr_data        = '0;
    ms_init        = 1'b0;
    ms_enable      = 1'b0;
    cm_rst_hash_n  = 1'b1;
    cm_update_A_H  = 1'b0;
    cm_update_H0_7 = 1'b0;
    cm_is_hashing  = 1'b0;
    hash_done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (ctrl_wr && listen_data[CTRL_START]) begin
          state_d    = RD_BLK;
          blk_d      = '0;
          word_d     = '0;
          dig_pass_d = 1'b0;
          dbl_d      = listen_data[CTRL_DOUBLE];
        end
      end
      RD_BLK: begin
        rd_en   = 1'b1;
        rd_addr = HCB_START + ADDR_W'(blk_q) * ADDR_W'(BLOCK_B);
        if (rd_valid) begin
          state_d = (blk_q == 3'd0) ? WR_BUSY : UPD1;
        end else if (wd_expired) begin
          state_d = WR_STAT;
          stat_d  = DATA_W'(STAT_TIMEOUT);
        end
      end
      WR_BUSY: begin
        wr_en   = 1'b1;
        wr_addr = ACB_START;
        wr_data = DATA_W'(STAT_BUSY);
        if (wr_done) begin
          state_d = INIT;
        end else if (wd_expired) begin
          state_d = WR_STAT;
          stat_d  = DATA_W'(STAT_TIMEOUT);
        end
      end
      INIT: begin
        cm_rst_hash_n = (blk_q != 3'd0);
        state_d       = UPD1;
      end
      UPD1: begin
        cm_update_A_H = 1'b1;
        ms_init       = 1'b1;
        state_d       = HASH;
      end
      HASH: begin
        cm_is_hashing = 1'b1;
        ms_enable     = 1'b1;
        if (last_round) state_d = UPD2;
      end
      UPD2: begin
        cm_update_H0_7 = 1'b1;
        state_d        = NEXT;
      end
      NEXT: begin
        if (!dig_pass_q && (blk_q < 3'(NUM_BLOCKS - 1))) begin
          blk_d   = blk_q + 3'd1;
          state_d = RD_BLK;
        end else if (dbl_q && !dig_pass_q) begin
          dig_pass_d = 1'b1;
          state_d    = UPD1;
        end else begin
          word_d  = '0;
          state_d = WR_HASH;
        end
      end
      WR_HASH: begin
        wr_en   = 1'b1;
        wr_addr = ACB_START + ADDR_W'(DIGEST_OFS) + ADDR_W'(word_q) * ADDR_W'(DATA_W / 8);
        wr_data = DATA_W'(cm_out[{word_q, 5'b0} +: 32]);
        if (wr_done) begin
          if (word_q == 3'd7) begin
            word_d  = '0;
            state_d = WR_STAT;
            stat_d  = DATA_W'(STAT_DONE);
          end else begin
            word_d = word_q + 3'd1;
          end
        end else if (wd_expired) begin
          word_d  = '0;
          state_d = WR_STAT;
          stat_d  = DATA_W'(STAT_TIMEOUT);
        end
      end
      WR_STAT: begin
        wr_en   = 1'b1;
        wr_addr = ACB_START;
        wr_data = stat_q;
        if (wr_done) begin
          hash_done  = 1'b1;
          state_d    = IDLE;
          blk_d      = '0;
          dig_pass_d = 1'b0;
          dbl_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort beats any handshake completing in the same cycle.
    if (abort && (state_q != IDLE) && (state_q != WR_HASH) && (state_q != WR_STAT)) begin
      state_d = WR_STAT;
      stat_d  = DATA_W'(STAT_ABORT);
      word_d  = '0;
    end
  end

endmodule

// File: tb/tb_acc_seq_control_unit.sv
// Directed bench for acc_seq_control_unit: table of job scenarios plus
// hand-written reset-mid-write sequence, with a 3-cycle-latency arbiter model.
module tb_acc_seq_control_unit;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam logic [15:0] ACB = 16'h5000;

  logic              clk;
  logic              rst_n;
  logic              listen_en;
  logic [ADDR_W-1:0] listen_addr;
  logic [DATA_W-1:0] listen_data;
  logic              rd_valid;
  logic              wr_done;
  logic [255:0]      cm_out;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              ms_init, ms_enable;
  logic              cm_rst_hash_n, cm_update_A_H, cm_update_H0_7, cm_is_hashing;
  logic [6:0]        cm_cycle_count;
  logic [2:0]        msg_sel;
  logic              hash_done;

  acc_seq_control_unit #(
    .ADDR_W(16), .DATA_W(32), .BLOCK_W(512),
    .HCB_START(16'h1000), .ACB_START(16'h5000),
    .NUM_BLOCKS(2), .HASH_ROUNDS(64), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .listen_en(listen_en), .listen_addr(listen_addr), .listen_data(listen_data),
    .rd_valid(rd_valid), .wr_done(wr_done), .cm_out(cm_out),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ms_init(ms_init), .ms_enable(ms_enable),
    .cm_rst_hash_n(cm_rst_hash_n), .cm_update_A_H(cm_update_A_H),
    .cm_update_H0_7(cm_update_H0_7), .cm_is_hashing(cm_is_hashing),
    .cm_cycle_count(cm_cycle_count), .msg_sel(msg_sel), .hash_done(hash_done)
  );

  typedef struct {
    logic [31:0] ctrl;
    int          abort_round;
    bit          rd_resp;
    bit          restart;
    int          exp_reads;
    int          exp_rd_cycles;
    int          exp_hash;
    int          exp_sel7;
    int          exp_init;
    int          exp_busy;
    int          exp_dig;
    logic [31:0] exp_stat;
  } vec_t;

  vec_t vecs[4];

  int checks, errors;
  bit rd_resp;

  int reads, rd_cycles, hash_cyc, sel7, init_cnt, busy_cnt, dig_cnt, dig_err, seq_err, done_cnt, exp_round;
  logic [31:0] last_stat;
  logic [15:0] rd_log[8];

  function automatic logic [31:0] dig_word(input int k);
    return 32'hC0DE_0000 + 32'(k) * 32'h0001_0101;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Arbiter: answers a request in its third cycle; one-cycle handshake pulse.
  initial begin
    int rc, wc;
    rc = 0;
    wc = 0;
    rd_valid = 1'b0;
    wr_done  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rd_valid) begin
        rd_valid = 1'b0;
        rc = 0;
      end else if (rd_en) begin
        rc++;
        if (rc == 3 && rd_resp) rd_valid = 1'b1;
      end else begin
        rc = 0;
      end
      if (wr_done) begin
        wr_done = 1'b0;
        wc = 0;
      end else if (wr_en) begin
        wc++;
        if (wc == 3) wr_done = 1'b1;
      end else begin
        wc = 0;
      end
    end
  end

  // Monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_en) rd_cycles++;
      if (rd_en && rd_valid) begin
        if (reads < 8) rd_log[reads] = rd_addr;
        reads++;
      end
      if (cm_is_hashing) begin
        hash_cyc++;
        if (msg_sel == 3'd7) sel7++;
        if (cm_cycle_count != 7'(exp_round)) seq_err++;
        exp_round = (exp_round == 63) ? 0 : exp_round + 1;
      end else begin
        exp_round = 0;
      end
      if (ms_enable != cm_is_hashing) seq_err++;
      if (!cm_rst_hash_n) init_cnt++;
      if (wr_en && wr_done) begin
        if (wr_addr == ACB) begin
          if (wr_data == 32'h5) busy_cnt++;
          else last_stat = wr_data;
        end else begin
          if (wr_addr != 16'(16'h5008 + 4 * dig_cnt) || wr_data != dig_word(dig_cnt)) dig_err++;
          dig_cnt++;
        end
      end
      if (hash_done) done_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    reads = 0; rd_cycles = 0; hash_cyc = 0; sel7 = 0; init_cnt = 0; busy_cnt = 0;
    dig_cnt = 0; dig_err = 0; seq_err = 0; done_cnt = 0; exp_round = 0;
    last_stat = '0;
    for (int k = 0; k < 8; k++) rd_log[k] = '0;
  endtask

  task automatic ctrl_write(input logic [31:0] d);
    @(negedge clk);
    listen_en   = 1'b1;
    listen_addr = ACB;
    listen_data = d;
    @(negedge clk);
    listen_en   = 1'b0;
    listen_data = '0;
  endtask

  task automatic check_idle(input string name);
    check({name, "_ctl"}, 32'({rd_en, wr_en, ms_init, ms_enable, cm_rst_hash_n,
                              cm_update_A_H, cm_update_H0_7, cm_is_hashing, hash_done}), 32'h010);
    check({name, "_bus"}, 32'(rd_addr | wr_addr | wr_data), 32'h0);
    check({name, "_sel"}, 32'({msg_sel, cm_cycle_count}), 32'h0);
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk);
      if (done_cnt > 0) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no hash_done expected one within 3000 cycles", name);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    bit found;
    clear_mon();
    rd_resp = v.rd_resp;
    ctrl_write(v.ctrl);
    if (v.restart) begin
      repeat (20) @(negedge clk);
      ctrl_write(32'h1);
    end
    if (v.abort_round >= 0) begin
      found = 1'b0;
      for (int c = 0; c < 2000 && !found; c++) begin
        @(negedge clk);
        if (cm_is_hashing && cm_cycle_count == 7'(v.abort_round)) found = 1'b1;
      end
      if (!found) begin
        checks++;
        errors++;
        $display("FAIL %s_abort_wait: got no round %0d expected it", name, v.abort_round);
      end else begin
        listen_en   = 1'b1;
        listen_addr = ACB;
        listen_data = 32'h8;
        @(negedge clk);
        listen_en   = 1'b0;
        listen_data = '0;
        check({name, "_abort_ms_enable"}, 32'(ms_enable), 32'h0);
      end
    end
    wait_done(name);
    check({name, "_reads"},     reads,     v.exp_reads);
    check({name, "_rd_cycles"}, rd_cycles, v.exp_rd_cycles);
    if (v.exp_reads > 0) check({name, "_rd_addr0"}, 32'(rd_log[0]), 32'h1000);
    if (v.exp_reads > 1) check({name, "_rd_addr1"}, 32'(rd_log[1]), 32'h1040);
    check({name, "_hash"},      hash_cyc,  v.exp_hash);
    check({name, "_sel7"},      sel7,      v.exp_sel7);
    check({name, "_init"},      init_cnt,  v.exp_init);
    check({name, "_busy"},      busy_cnt,  v.exp_busy);
    check({name, "_dig_cnt"},   dig_cnt,   v.exp_dig);
    check({name, "_dig_err"},   dig_err,   0);
    check({name, "_seq_err"},   seq_err,   0);
    check({name, "_status"},    last_stat, v.exp_stat);
    check({name, "_done"},      done_cnt,  1);
    rd_resp = 1'b1;
  endtask

  initial begin
    bit found;
    checks = 0;
    errors = 0;
    rd_resp = 1'b1;
    listen_en = 1'b0;
    listen_addr = '0;
    listen_data = '0;
    for (int k = 0; k < 8; k++) cm_out[32*k +: 32] = dig_word(k);
    clear_mon();

    //          ctrl   abort rd  rst reads rdcyc hash sel7 init busy dig stat
    vecs[0] = '{32'h1, -1,   1,  1,  2,    6,    128, 0,   1,   1,   8,  32'h2};
    vecs[1] = '{32'h3, -1,   1,  0,  2,    6,    192, 64,  1,   1,   8,  32'h2};
    vecs[2] = '{32'h1, 10,   1,  0,  1,    3,    11,  0,   1,   1,   0,  32'h12};
    vecs[3] = '{32'h1, -1,   0,  0,  0,    16,   0,   0,   0,   0,   0,  32'hA};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_low");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset_release");

    for (int n = 0; n < 4; n++) run_vec(vecs[n], $sformatf("vec%0d", n));

    // Reset in the middle of digest word 3 of a double job.
    clear_mon();
    ctrl_write(32'h3);
    found = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      @(negedge clk);
      if (wr_en && wr_addr == 16'h5014) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL midrst_wait: got no word-3 write expected one");
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_wr_en", 32'(wr_en), 32'h0);
    check_idle("midrst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("midrst_after");
    run_vec(vecs[0], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
